// File: rtl/mips_mc_pkg.sv
// Shared encodings, FSM states and ALU helpers for the multi-cycle MIPS core.
package mips_mc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_e;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_op_e;

   function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         OP_RTYPE: return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                          (fn == FN_OR)  || (fn == FN_SLT) || (fn == FN_JR);
         OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_LW, OP_SW: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Only R-type instructions select by funct; everything else adds.
   function automatic alu_op_e alu_sel(input logic [5:0] op, input logic [5:0] fn);
      if (op != OP_RTYPE) return ALU_ADD;
      case (fn)
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         FN_OR:   return ALU_OR;
         FN_SLT:  return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

   function automatic logic [31:0] alu_fn(input alu_op_e op, input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         ALU_SUB: return a - b;
         ALU_AND: return a & b;
         ALU_OR:  return a | b;
         ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
         default: return a + b;
      endcase
   endfunction

endpackage

// File: rtl/mips_multicycle_datapath_regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// register 0 hardwired to zero, asynchronous clear.
module regfile_2r1w (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd
);

   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];

   always_comb begin
      regs_d = regs_q;
      if (we && (wa != 5'd0)) regs_d[wa] = wd;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) regs_q <= '{default: '0};
      else     regs_q <= regs_d;
   end

   assign rd1 = (ra1 == 5'd0) ? 32'd0 : regs_q[ra1];
   assign rd2 = (ra2 == 5'd0) ? 32'd0 : regs_q[ra2];

endmodule

// File: rtl/mips_multicycle_datapath.sv
// Multi-cycle MIPS core with one shared req/ready memory port; wait states stall
// the FSM in FETCH or MEM with address, direction and store data held steady.
//
// state    | meaning
// FETCH    | read instruction at PC, PC += 4 on ready
// DECODE   | read rs/rt, precompute branch target, resolve j/jal, trap illegal
// EXEC     | ALU op, jr, beq resolution
// MEM      | lw/sw data transfer at ALUOut
// WB       | register write-back for R-type/addi/lw
// HALT     | illegal instruction seen; absorbing until reset
module mips_multicycle_datapath #(
   parameter int                 ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0,
   parameter int                 LINK_REG = 31
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] pc,
   output logic              retire,
   output logic              halted
);
   import mips_mc_pkg::*;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [31:0]       a_q, a_d;
   logic [31:0]       b_q, b_d;
   logic [31:0]       alu_out_q, alu_out_d;
   logic [31:0]       mdr_q, mdr_d;

   logic [5:0]  op, fn;
   logic [4:0]  rs, rt, rd;
   logic [31:0] imm_sext, pc_ext, br_tgt, jmp_tgt, alu_b, alu_res, rd1, rd2;
   logic        rf_we, mem_req_s;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;

   assign op       = ir_q[31:26];
   assign fn       = ir_q[5:0];
   assign rs       = ir_q[25:21];
   assign rt       = ir_q[20:16];
   assign rd       = ir_q[15:11];
   assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
   assign pc_ext   = 32'(pc_q);
   assign br_tgt   = pc_ext + {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
   assign jmp_tgt  = {pc_ext[31:28], ir_q[25:0], 2'b00};
   assign alu_b    = (op == OP_RTYPE) ? b_q : imm_sext;
   assign alu_res  = alu_fn(alu_sel(op, fn), a_q, alu_b);

   regfile_2r1w u_rf (
      .clk (clk),
      .rst (rst),
      .ra1 (rs),
      .ra2 (rt),
      .rd1 (rd1),
      .rd2 (rd2),
      .we  (rf_we),
      .wa  (rf_wa),
      .wd  (rf_wd)
   );

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      alu_out_d = alu_out_q;
      mdr_d     = mdr_q;
      rf_we     = 1'b0;
      rf_wa     = rt;
      rf_wd     = alu_out_q;
      retire    = 1'b0;
      mem_req_s = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = pc_q;
      mem_wdata = b_q;
      case (state_q)
         S_FETCH: begin
            mem_req_s = 1'b1;
            if (mem_ready) begin
               ir_d    = mem_rdata;
               pc_d    = pc_q + ADDR_W'(4);
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d       = rd1;
            b_d       = rd2;
            alu_out_d = br_tgt;
            if (!is_legal(op, fn)) begin
               state_d = S_HALT;
            end else if (op == OP_J || op == OP_JAL) begin
               // pc_q already holds the return address for jal.
               pc_d    = jmp_tgt[ADDR_W-1:0];
               rf_we   = (op == OP_JAL);
               rf_wa   = 5'(LINK_REG);
               rf_wd   = pc_ext;
               retire  = 1'b1;
               state_d = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (op == OP_RTYPE && fn == FN_JR) begin
               pc_d    = a_q[ADDR_W-1:0];
               retire  = 1'b1;
               state_d = S_FETCH;
            end else if (op == OP_BEQ) begin
               if (a_q == b_q) pc_d = alu_out_q[ADDR_W-1:0];
               retire  = 1'b1;
               state_d = S_FETCH;
            end else begin
               alu_out_d = alu_res;
               state_d   = (op == OP_LW || op == OP_SW) ? S_MEM : S_WB;
            end
         end
         S_MEM: begin
            mem_req_s = 1'b1;
            mem_addr  = alu_out_q[ADDR_W-1:0];
            mem_we    = (op == OP_SW);
            if (mem_ready) begin
               if (op == OP_SW) begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end else begin
                  mdr_d   = mem_rdata;
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            rf_we = 1'b1;
            if (op == OP_RTYPE) rf_wa = rd;
            if (op == OP_LW)    rf_wd = mdr_q;
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_HALT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         alu_out_q <= '0;
         mdr_q     <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         a_q       <= a_d;
         b_q       <= b_d;
         alu_out_q <= alu_out_d;
         mdr_q     <= mdr_d;
      end
   end

   assign mem_req = mem_req_s & ~rst;
   assign halted  = (state_q == S_HALT);
   assign pc      = pc_q;

endmodule

// File: tb/tb_mips_multicycle_datapath.sv
// Directed program run against a behavioural memory with programmable wait states.
module tb_mips_multicycle_datapath;

   logic        clk, rst;
   logic        mem_req, mem_we, mem_ready, retire, halted;
   logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;

   logic [31:0] mem [256];
   int          wcnt, wait_n;
   logic        patch_we;
   logic [7:0]  patch_idx;
   logic [31:0] patch_val;
   int          checks, failures;

   mips_multicycle_datapath #(.ADDR_W(32), .RESET_PC(32'h100), .LINK_REG(31)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .pc        (pc),
      .retire    (retire),
      .halted    (halted)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign mem_rdata = mem[mem_addr[9:2]];
   assign mem_ready = (wcnt >= wait_n);

   always @(posedge clk) begin
      if (patch_we) mem[patch_idx] <= patch_val;
      if (mem_req && mem_ready && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
      if (mem_req && mem_ready) wcnt <= 0;
      else if (mem_req)         wcnt <= wcnt + 1;
      else                      wcnt <= 0;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load_word(input logic [7:0] idx, input logic [31:0] val);
      patch_idx = idx;
      patch_val = val;
      patch_we  = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Checks the fetch address of one instruction and its cycle count up to retire.
   task automatic run_instr(input bit adv, input logic [31:0] exp_pc, input string tag,
                            input int exp_cyc);
      int n;
      if (adv) @(negedge clk);
      check({tag, "_fetch_addr"}, mem_addr, exp_pc);
      n = 1;
      while (!retire && n < 40) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_cycles"}, 32'(n), 32'(exp_cyc));
   endtask

   initial begin
      int n, w_fetch, w_mem, w_other, nz, bad;
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      wait_n   = 0;
      wcnt     = 0;
      patch_we = 1'b0;
      patch_idx = '0;
      patch_val = '0;

      load_word(8'd64, 32'h2001_0005);  // 0x100 addi $1,$0,5
      load_word(8'd65, 32'h2002_0007);  // 0x104 addi $2,$0,7
      load_word(8'd66, 32'h0022_1820);  // 0x108 add  $3,$1,$2
      load_word(8'd67, 32'hAC03_0040);  // 0x10C sw   $3,0x40($0)
      load_word(8'd68, 32'h8C04_0040);  // 0x110 lw   $4,0x40($0)
      load_word(8'd69, 32'h0800_0004);  // 0x114 j    0x10
      load_word(8'd4,  32'h1021_0002);  // 0x10  beq  $1,$1,+2
      load_word(8'd7,  32'h1022_0005);  // 0x1C  beq  $1,$2,+5
      load_word(8'd8,  32'h0C00_0040);  // 0x20  jal  0x100
      load_word(8'd9,  32'h2000_0009);  // 0x24  addi $0,$0,9
      load_word(8'd10, 32'h0022_2822);  // 0x28  sub  $5,$1,$2
      load_word(8'd11, 32'h0022_302A);  // 0x2C  slt  $6,$1,$2
      load_word(8'd12, 32'h00A1_382A);  // 0x30  slt  $7,$5,$1
      load_word(8'd13, 32'h0022_4024);  // 0x34  and  $8,$1,$2
      load_word(8'd14, 32'h0022_4825);  // 0x38  or   $9,$1,$2
      load_word(8'd15, 32'h8C0A_0040);  // 0x3C  lw   $10,0x40($0)
      load_word(8'd16, 32'h0000_0000);  // 0x40  data
      patch_we = 1'b0;

      check("rst_mem_req", 32'(mem_req), 32'd0);
      check("rst_halted",  32'(halted),  32'd0);
      check("rst_retire",  32'(retire),  32'd0);
      check("rst_pc",      pc,           32'h100);

      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("first_req", 32'(mem_req), 32'd1);
      check("first_we",  32'(mem_we),  32'd0);
      check("first_pc",  pc,           32'h100);
      run_instr(1'b0, 32'h100, "addi1", 4);

      // Replace 0x100 with jr $31 so the jal back to it returns to 0x24.
      patch_idx = 8'd64;
      patch_val = 32'h03E0_0008;
      patch_we  = 1'b1;

      run_instr(1'b1, 32'h104, "addi2", 4);
      run_instr(1'b1, 32'h108, "add", 4);
      run_instr(1'b1, 32'h10C, "sw", 4);
      check("sw_req",   32'(mem_req), 32'd1);
      check("sw_we",    32'(mem_we),  32'd1);
      check("sw_addr",  mem_addr,     32'h40);
      check("sw_wdata", mem_wdata,    32'd12);

      @(negedge clk);
      wait_n = 3;
      #1;
      check("lw_fetch_addr", mem_addr, 32'h110);
      check("sw_mem_word", mem[16], 32'd12);
      n = 1; w_fetch = 0; w_mem = 0; w_other = 0;
      while (!retire && n < 40) begin
         if (mem_req && !mem_ready) begin
            if (mem_addr == 32'h110 && !mem_we)     w_fetch++;
            else if (mem_addr == 32'h40 && !mem_we) w_mem++;
            else                                    w_other++;
         end
         @(negedge clk);
         n++;
      end
      check("lw_cycles",      32'(n),       32'd11);
      check("lw_fetch_waits", 32'(w_fetch), 32'd3);
      check("lw_mem_waits",   32'(w_mem),   32'd3);
      check("lw_bad_waits",   32'(w_other), 32'd0);
      wait_n = 0;

      run_instr(1'b1, 32'h114, "j", 2);
      run_instr(1'b1, 32'h10,  "beq_taken", 3);
      run_instr(1'b1, 32'h1C,  "beq_not_taken", 3);
      run_instr(1'b1, 32'h20,  "jal", 2);
      run_instr(1'b1, 32'h100, "jr", 3);
      run_instr(1'b1, 32'h24,  "addi_r0", 4);
      run_instr(1'b1, 32'h28,  "sub", 4);
      run_instr(1'b1, 32'h2C,  "slt", 4);
      run_instr(1'b1, 32'h30,  "slt_signed", 4);
      run_instr(1'b1, 32'h34,  "and", 4);
      run_instr(1'b1, 32'h38,  "or", 4);

      // lw $10 stalls in MEM; reset lands in the middle of the wait.
      @(negedge clk);
      check("lw10_fetch_addr", mem_addr, 32'h3C);
      repeat (3) @(negedge clk);
      wait_n = 8;
      #1;
      check("lw10_mem_req",  32'(mem_req), 32'd1);
      check("lw10_mem_addr", mem_addr,     32'h40);
      check("lw10_mem_we",   32'(mem_we),  32'd0);
      check("gpr0",  dut.u_rf.regs_q[0],  32'd0);
      check("gpr1",  dut.u_rf.regs_q[1],  32'd5);
      check("gpr2",  dut.u_rf.regs_q[2],  32'd7);
      check("gpr3",  dut.u_rf.regs_q[3],  32'd12);
      check("gpr4",  dut.u_rf.regs_q[4],  32'd12);
      check("gpr5",  dut.u_rf.regs_q[5],  32'hFFFF_FFFE);
      check("gpr6",  dut.u_rf.regs_q[6],  32'd1);
      check("gpr7",  dut.u_rf.regs_q[7],  32'd1);
      check("gpr8",  dut.u_rf.regs_q[8],  32'd5);
      check("gpr9",  dut.u_rf.regs_q[9],  32'd7);
      check("gpr31", dut.u_rf.regs_q[31], 32'h24);

      @(negedge clk);
      #3 rst = 1'b1;
      #1;
      check("abort_mem_req", 32'(mem_req), 32'd0);
      check("abort_pc",      pc,           32'h100);
      check("abort_retire",  32'(retire),  32'd0);
      nz = 0;
      for (int i = 0; i < 32; i++) if (dut.u_rf.regs_q[i] !== 32'd0) nz++;
      check("abort_gprs_nonzero", 32'(nz), 32'd0);

      patch_idx = 8'd64;
      patch_val = 32'hFC00_0000;  // opcode 111111
      wait_n    = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("restart_req",  32'(mem_req), 32'd1);
      check("restart_addr", mem_addr,     32'h100);
      @(negedge clk);
      check("decode_halted", 32'(halted), 32'd0);
      @(negedge clk);
      check("halt_halted", 32'(halted),  32'd1);
      check("halt_pc",     pc,           32'h104);
      check("halt_req",    32'(mem_req), 32'd0);
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (mem_req !== 1'b0 || halted !== 1'b1 || retire !== 1'b0 || pc !== 32'h104) bad++;
      end
      check("halt_hold_violations", 32'(bad), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
